// File: rtl/fetch_queue_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_unit
// Description : Decoupled instruction-fetch front end. Pipelined in-order
//               memory requests feed an instruction FIFO toward decode; stale
//               responses after a redirect/flush are discarded via a drop count.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_unit #(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int INST_BYTES        = 4,
  parameter int QUEUE_DEPTH       = 4,
  parameter int MAX_OUTSTANDING   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDRESS_WIDTH-1:0]     entry,
  input  logic                         in_redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_redirect_target,
  input  logic                         in_flush_valid,
  input  logic [ADDRESS_WIDTH-1:0]     in_flush_addrplus1,
  output logic                         out_imem_req_valid,
  input  logic                         in_imem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]     out_imem_req_addr,
  input  logic                         in_imem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] in_imem_resp_data,
  output logic                         out_valid,
  input  logic                         in_ready,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction_bits,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus1
);

  localparam int QAW  = $clog2(QUEUE_DEPTH);
  localparam int QCW  = $clog2(QUEUE_DEPTH + 1);
  localparam int OCW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int TAW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SUMW = ((QCW > OCW) ? QCW : OCW) + 1;

  localparam logic [ADDRESS_WIDTH-1:0] c_inst_bytes = ADDRESS_WIDTH'(INST_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] c_align_mask = ~ADDRESS_WIDTH'(INST_BYTES - 1);
  localparam logic [OCW-1:0]           c_max_out    = OCW'(MAX_OUTSTANDING);
  localparam logic [SUMW-1:0]          c_depth      = SUMW'(QUEUE_DEPTH);
  localparam logic [TAW-1:0]           c_tag_last   = TAW'(MAX_OUTSTANDING - 1);

  logic [ADDRESS_WIDTH-1:0]     r_fpc;
  logic                         r_reset_d;
  logic [QCW-1:0]               r_count;
  logic [QAW-1:0]               r_head;
  logic [QAW-1:0]               r_tail;
  logic [INSTRUCTION_WIDTH-1:0] r_q_data [QUEUE_DEPTH];
  logic [ADDRESS_WIDTH-1:0]     r_q_pc   [QUEUE_DEPTH];
  logic [OCW-1:0]               r_out;
  logic [OCW-1:0]               r_drop;
  logic [ADDRESS_WIDTH-1:0]     r_tag_mem [MAX_OUTSTANDING];
  logic [TAW-1:0]               r_tag_wr;
  logic [TAW-1:0]               r_tag_rd;

  logic                         w_event;
  logic [ADDRESS_WIDTH-1:0]     w_target;
  logic                         w_credit_ok;
  logic                         w_req_valid;
  logic                         w_hs;
  logic                         w_head_valid;
  logic                         w_pop;
  logic                         w_push;
  logic [TAW-1:0]               w_tag_wr_next;
  logic [TAW-1:0]               w_tag_rd_next;

  assign w_event     = in_flush_valid | in_redirect_valid;
  assign w_target    = (in_flush_valid ? in_flush_addrplus1 : in_redirect_target) & c_align_mask;
  // Reserving a queue slot per in-flight request lets every response be accepted.
  assign w_credit_ok = (SUMW'(r_count) + SUMW'(r_out)) < c_depth;
  assign w_req_valid = !reset && !r_reset_d && !w_event && (r_out < c_max_out) && w_credit_ok;
  assign w_hs        = w_req_valid && in_imem_req_ready;

  assign w_head_valid = !reset && (r_count != '0);
  assign w_pop        = w_head_valid && in_ready && !w_event;
  assign w_push       = in_imem_resp_valid && (r_drop == '0) && !w_event;

  assign w_tag_wr_next = (r_tag_wr == c_tag_last) ? '0 : r_tag_wr + TAW'(1);
  assign w_tag_rd_next = (r_tag_rd == c_tag_last) ? '0 : r_tag_rd + TAW'(1);

  always_ff @(posedge clk) begin
    r_reset_d <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc    <= entry;
      r_count  <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_out    <= '0;
      r_drop   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
    end else begin
      r_out <= r_out + OCW'(w_hs) - OCW'(in_imem_resp_valid);
      if (w_hs) begin
        r_tag_wr <= w_tag_wr_next;
      end
      if (in_imem_resp_valid) begin
        r_tag_rd <= w_tag_rd_next;
      end
      if (w_event) begin
        r_fpc   <= w_target;
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        // Earlier stale requests are still counted in r_out, so this covers them too.
        r_drop  <= r_out - OCW'(in_imem_resp_valid);
      end else begin
        if (w_hs) begin
          r_fpc <= r_fpc + c_inst_bytes;
        end
        if (in_imem_resp_valid && (r_drop != '0)) begin
          r_drop <= r_drop - OCW'(1);
        end
        if (w_push) begin
          r_tail <= r_tail + QAW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + QAW'(1);
        end
        r_count <= r_count + QCW'(w_push) - QCW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_tag_mem[r_tag_wr] <= r_fpc;
    end
    if (w_push) begin
      r_q_data[r_tail] <= in_imem_resp_data;
      r_q_pc[r_tail]   <= r_tag_mem[r_tag_rd];
    end
  end

  assign out_imem_req_valid   = w_req_valid;
  assign out_imem_req_addr    = (reset || r_reset_d) ? '0 : r_fpc;
  assign out_valid            = w_head_valid;
  assign out_instruction_bits = w_head_valid ? r_q_data[r_head] : '0;
  assign out_pc               = w_head_valid ? r_q_pc[r_head] : '0;
  assign out_pcplus1          = w_head_valid ? (r_q_pc[r_head] + c_inst_bytes) : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_unit.sv
`default_nettype none
// Testbench for fetch_queue_unit: in-order memory model with random latency,
// epoch-based reference model feeding a scoreboard checked by a monitor.
module tb_fetch_queue_unit;

  localparam int AW = 64;
  localparam int IW = 32;
  localparam int QD = 4;
  localparam int MO = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] entry;
  logic          in_redirect_valid;
  logic [AW-1:0] in_redirect_target;
  logic          in_flush_valid;
  logic [AW-1:0] in_flush_addrplus1;
  logic          out_imem_req_valid;
  logic          in_imem_req_ready;
  logic [AW-1:0] out_imem_req_addr;
  logic          in_imem_resp_valid;
  logic [IW-1:0] in_imem_resp_data;
  logic          out_valid;
  logic          in_ready;
  logic [IW-1:0] out_instruction_bits;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pcplus1;

  fetch_queue_unit #(
    .ADDRESS_WIDTH(AW), .INSTRUCTION_WIDTH(IW), .INST_BYTES(4),
    .QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .entry(entry),
    .in_redirect_valid(in_redirect_valid), .in_redirect_target(in_redirect_target),
    .in_flush_valid(in_flush_valid), .in_flush_addrplus1(in_flush_addrplus1),
    .out_imem_req_valid(out_imem_req_valid), .in_imem_req_ready(in_imem_req_ready),
    .out_imem_req_addr(out_imem_req_addr),
    .in_imem_resp_valid(in_imem_resp_valid), .in_imem_resp_data(in_imem_resp_data),
    .out_valid(out_valid), .in_ready(in_ready),
    .out_instruction_bits(out_instruction_bits), .out_pc(out_pc), .out_pcplus1(out_pcplus1)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [AW-1:0] pc; logic [IW-1:0] data; } exp_t;

  mreq_t         mq[$];      // accepted, unanswered requests (memory side)
  exp_t          exp_q[$];   // expected queue contents, oldest first
  logic [AW-1:0] popped[$];  // PCs delivered to decode
  logic [AW-1:0] model_fpc;
  int            cur_epoch = 0;
  int            cyc = 0;
  int            issued = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  bit            mon_en = 0;
  logic [IW-1:0] key = '0;
  bit            g_rq_rdy = 1, g_dec_rdy = 1, g_resp_en = 1;
  int            lat_min = 1, lat_max = 1;

  function automatic logic [IW-1:0] mdata(input logic [AW-1:0] a);
    return a[IW-1:0] ^ key;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_popped(input string name, input int idx, input logic [AW-1:0] exp);
    if (popped.size() > idx) check(name, popped[idx], exp);
    else begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: only %0d instructions delivered, expected pc %h at index %0d",
               name, popped.size(), exp, idx);
    end
  endtask

  // Monitor: compares the head against the scoreboard whenever decode takes it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
        if (out_valid && in_ready && !(in_redirect_valid || in_flush_valid) && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_pcplus1", out_pcplus1, e.pc + 64'd4);
          check("out_bits", {32'd0, out_instruction_bits}, {32'd0, e.data});
          popped.push_back(out_pc);
        end else if (!out_valid) begin
          check("idle_pc_zero", out_pc, '0);
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_req_valid"}, {63'd0, out_imem_req_valid}, '0);
    check({tag, "_out_valid"}, {63'd0, out_valid}, '0);
    check({tag, "_pc"}, out_pc, '0);
    check({tag, "_req_addr"}, out_imem_req_addr, '0);
  endtask

  task automatic do_reset(input logic [AW-1:0] ev);
    @(negedge clk);
    mon_en = 0;
    reset = 1;
    entry = ev;
    in_redirect_valid = 0;
    in_flush_valid = 0;
    in_imem_resp_valid = 0;
    in_imem_resp_data = '0;
    mq.delete();
    exp_q.delete();
    cur_epoch++;
    model_fpc = ev;
    for (int i = 0; i < 2; i++) begin
      #1 check_zero_outputs("rst");
      @(negedge clk);
    end
    reset = 0;
    entry = '0;
    mon_en = 1;
    #1 check_zero_outputs("post_rst");
  endtask

  // One clock of stimulus with reference-model bookkeeping.
  task automatic step(input bit rv, input logic [AW-1:0] rt, input bit fv, input logic [AW-1:0] fa);
    bit   ev, resp, exp_req, hs, push;
    exp_t pend;
    mreq_t m;
    @(negedge clk);
    in_imem_req_ready  = g_rq_rdy;
    in_ready           = g_dec_rdy;
    in_redirect_valid  = rv;
    in_redirect_target = rt;
    in_flush_valid     = fv;
    in_flush_addrplus1 = fa;
    resp = g_resp_en && mq.size() > 0 && mq[0].due <= cyc;
    in_imem_resp_valid = resp;
    in_imem_resp_data  = resp ? mdata(mq[0].addr) : '0;
    #1;
    ev = rv || fv;
    exp_req = !ev && (mq.size() < MO) && (exp_q.size() + mq.size() < QD);
    check("req_valid", {63'd0, out_imem_req_valid}, {63'd0, exp_req});
    push = 0;
    if (resp) begin
      m = mq.pop_front();
      if (m.epoch == cur_epoch && !ev) begin
        push = 1;
        pend.pc = m.addr;
        pend.data = mdata(m.addr);
      end
    end
    hs = out_imem_req_valid && g_rq_rdy;
    if (hs) begin
      check("req_addr", out_imem_req_addr, model_fpc);
      m.addr = model_fpc;
      m.epoch = cur_epoch;
      m.due = cyc + $urandom_range(lat_min, lat_max);
      mq.push_back(m);
      model_fpc = model_fpc + 64'd4;
      issued++;
    end
    @(posedge clk);
    if (ev) begin
      exp_q.delete();
      model_fpc = (fv ? fa : rt) & ~64'd3;
      cur_epoch++;
    end else if (push) begin
      exp_q.push_back(pend);
    end
    cyc++;
  endtask

  task automatic step0();
    step(0, '0, 0, '0);
  endtask

  task automatic run_until_pop(input int max);
    for (int i = 0; i < max && popped.size() == 0; i++) step0();
  endtask

  initial begin
    reset = 1; entry = '0;
    in_redirect_valid = 0; in_redirect_target = '0;
    in_flush_valid = 0; in_flush_addrplus1 = '0;
    in_imem_req_ready = 1; in_imem_resp_valid = 0; in_imem_resp_data = '0; in_ready = 1;

    // Boot stream, 1-cycle memory
    do_reset(64'h1000);
    popped.delete();
    repeat (20) step0();
    check_popped("boot_pc0", 0, 64'h1000);
    check_popped("boot_pc2", 2, 64'h1008);
    check("boot_throughput", {63'd0, popped.size() >= 15}, 64'd1);

    // Backpressure
    do_reset(64'h1000);
    g_dec_rdy = 0;
    issued = 0;
    repeat (10) step0();
    check("bp_issued", 64'(issued), 64'd4);
    #1 check("bp_head_pc", out_pc, 64'h1000);
    g_dec_rdy = 1;
    popped.delete();
    repeat (12) step0();
    check_popped("bp_release0", 0, 64'h1000);
    check_popped("bp_release3", 3, 64'h100C);
    check_popped("bp_release4", 4, 64'h1010);

    // Redirect with two requests in flight
    lat_min = 3; lat_max = 3;
    do_reset(64'h1000);
    for (int i = 0; i < 20 && mq.size() < 2; i++) step0();
    check("rd_inflight", 64'(mq.size()), 64'd2);
    popped.delete();
    step(1, 64'h2002, 0, '0);
    run_until_pop(30);
    check_popped("rd_first_pc", 0, 64'h2000);

    // Flush and branch together
    lat_min = 1; lat_max = 2;
    repeat (5) step0();
    popped.delete();
    step(1, 64'h4000, 1, 64'h3000);
    run_until_pop(30);
    check_popped("flush_prio_pc", 0, 64'h3000);

    // Event coinciding with a response and a pop
    lat_min = 1; lat_max = 1;
    repeat (8) step0();
    #1 check("coll_setup_valid", {63'd0, out_valid}, 64'd1);
    popped.delete();
    step(1, 64'h6000, 0, '0);
    #1 check("coll_after_valid", {63'd0, out_valid}, '0);
    run_until_pop(30);
    check_popped("coll_first_pc", 0, 64'h6000);
    repeat (6) step0();
    check_popped("coll_second_pc", 1, 64'h6004);

    // Address wrap, then reset mid-stream
    do_reset(64'hFFFF_FFFF_FFFF_FFFC);
    popped.delete();
    repeat (8) step0();
    check_popped("wrap_pc0", 0, 64'hFFFF_FFFF_FFFF_FFFC);
    check_popped("wrap_pc1", 1, 64'h0);
    lat_min = 2; lat_max = 3;
    repeat (3) step0();
    do_reset(64'h5000);
    popped.delete();
    run_until_pop(30);
    check_popped("rst_mid_pc", 0, 64'h5000);

    // Randomized traffic
    key = $urandom;
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      bit rv, fv;
      g_rq_rdy  = ($urandom_range(0, 3) != 0);
      g_dec_rdy = ($urandom_range(0, 2) != 0);
      g_resp_en = ($urandom_range(0, 4) != 0);
      rv = ($urandom_range(0, 99) < 4);
      fv = ($urandom_range(0, 99) < 2);
      step(rv, {$urandom, $urandom}, fv, {$urandom, $urandom});
    end
    g_resp_en = 1; g_dec_rdy = 1;
    repeat (20) step0();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
